mac_seq_divider: RTL and testbench

Iterative restoring divider that reverses the MAC datapath's add/accumulate direction. It takes an unsigned accumulated result and divides it by an unsigned divisor, for example for averaging or normalising a MAC output. It produces one quotient bit per clock using a trial subtraction, computed as a two's-complement addition through the same prefix-adder style used by the MAC adders. It sits downstream of the MAC accumulator and is started by a one-cycle pulse.

---
 rtl/mac_seq_divider.sv | 131 +++++++++++++
 tb/tb_mac_seq_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_divider.sv
// mac_seq_divider: iterative restoring unsigned divider.
// One quotient bit per clock; trial subtract through a prefix adder.
module mac_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH);
  localparam int LV = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_zpend;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_qbit;
  logic             w_accept;

  always_comb begin
    logic [WIDTH:0] b;
    logic [WIDTH:0] p;
    logic [WIDTH:0] g;
    logic [WIDTH:0] gp;
    logic [WIDTH:0] pp;
    w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    b  = ~{1'b0, r_dvs};
    p  = w_shift ^ b;
    g  = w_shift & b;
    gp = g;
    pp = p;
    // carry-in of 1 (two's complement) folds into bit 0
    gp[0] = g[0] | p[0];
    for (int l = 0; l < LV; l++) begin
      for (int i = N - 1; i >= (1 << l); i--) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    w_t       = p ^ {gp[WIDTH-1:0], 1'b1};
    w_qbit    = ~w_t[WIDTH];
    w_rem_nxt = w_qbit ? w_t : w_shift;
    w_q_nxt   = {r_q[WIDTH-2:0], w_qbit};
  end

  assign w_accept = start &&
    ((r_state == S_IDLE) ||
     ((r_state == S_DONE) && !r_zpend));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dvs       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_zpend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_q_nxt;
            remainder <= w_rem_nxt[WIDTH-1:0];
          end
        end
        S_DONE: begin
          // zero divisor spends one settle cycle before pulsing done
          if (r_zpend) begin
            r_zpend     <= 1'b0;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= r_q;
            div_by_zero <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: ;
      endcase
      if (w_accept) begin
        r_dvs       <= divisor;
        r_q         <= dividend;
        r_rem       <= '0;
        r_cnt       <= CW'(WIDTH - 1);
        div_by_zero <= 1'b0;
        if (divisor != '0) begin
          r_state <= S_RUN;
          busy    <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_zpend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_divider.sv
// tb_mac_seq_divider: random + directed bench for mac_seq_divider.
// Cycle-level reference model built from quotient/remainder arithmetic.
module tb_mac_seq_divider;

  localparam int W    = 16;
  localparam int MAXV = (1 << W) - 1;
  localparam int NRND = 3500;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mac_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: edge count plus the scheduled done edge.
  int     m_cyc = 0;
  int     m_done_at = -10;
  int     m_rs = -10;
  int     m_re = -20;
  longint m_q = 0, m_r = 0, m_z = 0;
  longint p_q = 0, p_r = 0, p_z = 0;

  always @(posedge clk) begin
    m_cyc++;
    if (rst) begin
      m_done_at = -10;
      m_rs = -10;
      m_re = -20;
      m_q = 0;
      m_r = 0;
      m_z = 0;
    end else begin
      if (m_cyc == m_done_at) begin
        m_q = p_q;
        m_r = p_r;
        m_z = p_z;
      end
      if (start && m_cyc > m_done_at) begin
        m_z = 0;
        if (divisor != 0) begin
          p_q = longint'(dividend) / longint'(divisor);
          p_r = longint'(dividend) % longint'(divisor);
          p_z = 0;
          m_done_at = m_cyc + W;
          m_rs = m_cyc;
          m_re = m_cyc + W - 1;
        end else begin
          p_q = MAXV;
          p_r = longint'(dividend);
          p_z = 1;
          m_done_at = m_cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done, m_cyc == m_done_at);
      chk("busy", busy, m_cyc >= m_rs && m_cyc <= m_re);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
  end

  task automatic start_op(input int dd, input int dv);
    dividend = W'(dd);
    divisor  = W'(dv);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit got,
                           output int lat, output int bcnt);
    got  = 1'b0;
    lat  = 0;
    bcnt = int'(busy);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = k + 2;
        break;
      end
      bcnt += int'(busy);
    end
  endtask

  task automatic op_lit(input string nm, input int dd, input int dv,
                        input int eq, input int er, input int ez,
                        input int elat, input int ebusy);
    bit got;
    int lat, bc;
    start_op(dd, dv);
    wait_done(W + 4, got, lat, bc);
    chk({nm, " done seen"}, got, 1);
    chk({nm, " q"}, quotient, eq);
    chk({nm, " r"}, remainder, er);
    chk({nm, " dbz"}, div_by_zero, ez);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy cycles"}, bc, ebusy);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bit got;
    int lat, bc;
    int dd, dv, r;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset q", quotient, 0);
    chk("reset r", remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    op_lit("100/7", 100, 7, 14, 2, 0, W + 1, W);
    @(negedge clk);
    op_lit("FFFF/1", MAXV, 1, MAXV, 0, 0, W + 1, W);
    op_lit("FFFF/FFFF", MAXV, MAXV, 1, 0, 0, W + 1, W);
    op_lit("3/10", 3, 10, 0, 3, 0, W + 1, W);
    @(negedge clk);
    op_lit("5/0", 5, 0, MAXV, 5, 1, 2, 0);
    op_lit("9/3", 9, 3, 3, 0, 0, W + 1, W);
    @(negedge clk);

    // starts during RUN are dropped; then a back-to-back start
    start_op(100, 7);
    repeat (3) @(negedge clk);
    dividend = 1;
    divisor  = 1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W, got, lat, bc);
    chk("ignore done seen", got, 1);
    chk("ignore q", quotient, 14);
    chk("ignore r", remainder, 2);
    op_lit("b2b 50/6", 50, 6, 8, 2, 0, W + 1, W);
    @(negedge clk);

    // reset in the middle of a run
    start_op(100, 7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst q", quotient, 0);
    chk("midrst r", remainder, 0);
    wait_done(W + 4, got, lat, bc);
    chk("midrst no done", got, 0);
    op_lit("1000/33", 1000, 33, 30, 10, 0, W + 1, W);
    @(negedge clk);

    dd = int'($urandom_range(0, MAXV));
    dv = 7;
    for (int n = 0; n < NRND; n++) begin
      start_op(dd, dv);
      wait_done(W + 4, got, lat, bc);
      chk("rnd done seen", got, 1);
      chk("rnd latency", lat, (dv == 0) ? 2 : W + 1);
      if (dv != 0) begin
        chk("rnd invariant",
            longint'(quotient) * dv + remainder, dd);
        chk("rnd rem<div", remainder < W'(dv), 1);
      end else begin
        chk("rnd zero q", quotient, MAXV);
        chk("rnd zero r", remainder, dd);
        chk("rnd zero dbz", div_by_zero, 1);
      end
      dd = int'($urandom_range(0, MAXV));
      r  = int'($urandom_range(0, 99));
      if (r < 5) dv = 0;
      else if (r < 40) dv = int'($urandom_range(1, 255));
      else dv = int'($urandom_range(1, MAXV));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
